// File: rtl/regfile_pkg.sv
// Shared constants and types for the two-read, one-write register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // Entry that reads as zero when the zero-register option is enabled
    localparam addr_t ZERO_ADDR = '0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-entry pending bits: alloc marks an entry as awaiting a producer,
// a write retires it. Exposes next-state readiness for both read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_dest,
    input  logic              we,
    input  logic [ADDR_W-1:0] dest,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    output logic              ready_a_d,
    output logic              ready_b_d
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Clear on write, then set on alloc so a same-cycle newer producer wins
    always_comb begin
        pending_d = pending_q;
        if (we) begin
            pending_d[dest] = 1'b0;
        end
        if (alloc_en) begin
            pending_d[alloc_dest] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[ZERO_A] = 1'b0;
        end
    end

    // Pending-bit storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Readiness reflects this edge's set/clear updates
    assign ready_a_d = ~pending_d[address_a];
    assign ready_b_d = ~pending_d[address_b];

endmodule : regfile_scoreboard

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two registered read ports with write bypass,
// one write port, and a pending bit per entry for operand readiness.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] data,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_dest,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              ready_a,
    output logic              ready_b,
    output logic              out_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wr_sel;

    logic [DATA_W-1:0] rd_a_d;
    logic [DATA_W-1:0] rd_b_d;
    logic              ready_a_d;
    logic              ready_b_d;

    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic              ready_a_q;
    logic              ready_b_q;
    logic              out_valid_q;

    // Per-entry write strobe; entry 0 is never written in zero-register mode
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign wr_sel[gi] = 1'b0;
        end else begin : g_norm
            assign wr_sel[gi] = we && (dest == ADDR_W'(gi));
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_q[i] <= data;
                end
            end
        end
    end

    // Read muxes: zero register first, then same-cycle write bypass, then array
    always_comb begin
        rd_a_d = mem_q[address_a];
        rd_b_d = mem_q[address_b];
        if (we && dest == address_a) begin
            rd_a_d = data;
        end
        if (we && dest == address_b) begin
            rd_b_d = data;
        end
        if (ZERO_REG != 0 && address_a == ZERO_A) begin
            rd_a_d = '0;
        end
        if (ZERO_REG != 0 && address_b == ZERO_A) begin
            rd_b_d = '0;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_en),
        .alloc_dest (alloc_dest),
        .we         (we),
        .dest       (dest),
        .address_a  (address_a),
        .address_b  (address_b),
        .ready_a_d  (ready_a_d),
        .ready_b_d  (ready_b_d)
    );

    // Output registers load on a read and hold otherwise; valid pulses one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_q     <= '0;
            out_b_q     <= '0;
            ready_a_q   <= 1'b1;
            ready_b_q   <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_en;
            if (rd_en) begin
                out_a_q   <= rd_a_d;
                out_b_q   <= rd_b_d;
                ready_a_q <= ready_a_d;
                ready_b_q <= ready_b_d;
            end
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign ready_a   = ready_a_q;
    assign ready_b   = ready_b_q;
    assign out_valid = out_valid_q;

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: stimulus pushes expected read results,
// a monitor pops and compares whenever out_valid is high.
module tb_regfile_2r1w;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] address_a;
    logic [AW-1:0] address_b;
    logic          we;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic          alloc_en;
    logic [AW-1:0] alloc_dest;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          ready_a;
    logic          ready_b;
    logic          out_valid;

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .address_a  (address_a),
        .address_b  (address_b),
        .we         (we),
        .dest       (dest),
        .data       (data),
        .alloc_en   (alloc_en),
        .alloc_dest (alloc_dest),
        .out_a      (out_a),
        .out_b      (out_b),
        .ready_a    (ready_a),
        .ready_b    (ready_b),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ra;
        logic          rb;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    // Reference model: plain arrays indexed by register number
    int unsigned model_mem [DEPTH];
    bit          model_busy[DEPTH];

    int total = 0;
    int bad   = 0;
    int n_reads = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = 0;
            model_busy[i] = 0;
        end
        exp_q.delete();
        last_exp.a  = '0;
        last_exp.b  = '0;
        last_exp.ra = 1'b1;
        last_exp.rb = 1'b1;
    endtask

    // Value a read of register r sees, given this cycle's write
    function automatic int unsigned read_val(int r, bit w, int d, int unsigned v);
        if (r == 0) return 0;
        if (w && d == r) return v;
        return model_mem[r];
    endfunction

    // Apply one cycle of stimulus at the falling edge and record the expectation
    task automatic drive(input bit rd, input int a, input int b,
                         input bit w, input int d, input int unsigned v,
                         input bit al, input int ald);
        exp_t e;
        bit busy_after[DEPTH];
        @(negedge clk);
        rd_en      = rd;
        address_a  = AW'(a);
        address_b  = AW'(b);
        we         = w;
        dest       = AW'(d);
        data       = DW'(v);
        alloc_en   = al;
        alloc_dest = AW'(ald);
        busy_after = model_busy;
        if (w)  busy_after[d]   = 0;
        if (al) busy_after[ald] = 1;
        busy_after[0] = 0;
        if (rd) begin
            e.a  = DW'(read_val(a, w, d, v));
            e.b  = DW'(read_val(b, w, d, v));
            e.ra = !busy_after[a];
            e.rb = !busy_after[b];
            exp_q.push_back(e);
            $display("read  a=%0d b=%0d we=%0b dest=%0d data=%02h alloc=%0b/%0d -> exp a=%02h b=%02h ra=%0b rb=%0b",
                     a, b, w, d, v, al, ald, e.a, e.b, e.ra, e.rb);
        end
        if (w && d != 0) model_mem[d] = v;
        model_busy = busy_after;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare on every out_valid, check hold when not valid
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_reads++;
                    chk("out_a",   out_a,   e.a);
                    chk("out_b",   out_b,   e.b);
                    chk("ready_a", ready_a, e.ra);
                    chk("ready_b", ready_b, e.rb);
                    last_exp = e;
                end
            end else begin
                chk("hold_a",       out_a,   last_exp.a);
                chk("hold_b",       out_b,   last_exp.b);
                chk("hold_ready_a", ready_a, last_exp.ra);
                chk("hold_ready_b", ready_b, last_exp.rb);
                chk("valid_missing", exp_q.size(), 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rd_en = 0; address_a = 0; address_b = 0; we = 0; dest = 0;
        data = 0; alloc_en = 0; alloc_dest = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_a",   out_a,     0);
        chk("rst_out_b",   out_b,     0);
        chk("rst_ready_a", ready_a,   1);
        chk("rst_ready_b", ready_b,   1);
        chk("rst_valid",   out_valid, 0);

        // 1. read after reset
        drive(1, 3, 7, 0, 0, 0, 0, 0);
        // 2. write then read, then hold
        drive(0, 0, 0, 1, 5, 'hA5, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // 3. bypass on both ports
        drive(1, 2, 2, 1, 2, 'h3C, 0, 0);
        // 4. zero register ignores writes and allocations
        drive(0, 0, 0, 1, 0, 'hFF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0, 'hEE, 1, 0);
        // 5. scoreboard set/clear/priority
        drive(0, 0, 0, 0, 0, 0, 1, 4);
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 'h11, 0, 0);
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 1, 4, 'h22, 1, 4);
        drive(1, 4, 4, 0, 0, 0, 1, 4);
        drive(1, 4, 1, 1, 4, 'h33, 0, 0);
        // 6. async reset mid-operation
        drive(0, 0, 0, 1, 9, 'h77, 1, 9);
        drive(1, 9, 9, 0, 0, 0, 0, 0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_a",   out_a,     0);
        chk("arst_out_b",   out_b,     0);
        chk("arst_ready_a", ready_a,   1);
        chk("arst_ready_b", ready_b,   1);
        chk("arst_valid",   out_valid, 0);
        model_reset();
        #1 rst_n = 1'b1;
        drive(1, 9, 5, 0, 0, 0, 0, 0);

        // Randomized traffic; narrow address range half the time to force collisions
        for (int i = 0; i < 400; i++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 0) ? 3 : 15;
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, hi), $urandom_range(0, hi),
                  $urandom_range(0, 1) == 1, $urandom_range(0, hi), $urandom_range(0, 255),
                  $urandom_range(0, 2) == 0, $urandom_range(0, hi));
        end

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        idle();
        chk("drain_left", exp_q.size(), 0);
        if (n_reads == 0) chk("reads_seen", n_reads, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_2r1w
